// File: rtl/ddio_out_pkg.sv
// Shared types and constants for the DDIO output burst formatter.
package ddio_out_pkg;

    // Burst framing states.
    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StData,
        StPost
    } burst_state_e;

    // Width of the PRE/POST down-counter.
    localparam int unsigned CNT_W = 4;

    // Legal framing lengths.
    localparam int unsigned PRE_MIN  = 1;
    localparam int unsigned PRE_MAX  = 15;
    localparam int unsigned POST_MIN = 0;
    localparam int unsigned POST_MAX = 15;

endpackage

// File: rtl/ddio_out_burst_ctrl.sv
// Burst formatter feeding a DDIO output cell: splits each double-width stream word into
// high-edge and low-edge halves and frames each burst with zero-data preamble/postamble
// cycles while output-enable is held high. Stalls inside a burst insert a zero cycle and
// raise a one-cycle underrun pulse.
module ddio_out_burst_ctrl
    import ddio_out_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PREAMBLE  = 1,
    parameter int unsigned POSTAMBLE = 1
) (
    input  logic               clk,
    input  logic               sreset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic [WIDTH-1:0]   datain_h,
    output logic [WIDTH-1:0]   datain_l,
    output logic               oe,
    output logic               clkena,
    output logic               busy,
    output logic               underrun
);

    // Counter reload values; the counter runs from N-1 down to 0 so a phase lasts N cycles.
    localparam logic [CNT_W-1:0] PreLoad  = CNT_W'(PREAMBLE - 1);
    localparam logic [CNT_W-1:0] PostLoad = (POSTAMBLE > 0) ? CNT_W'(POSTAMBLE - 1) : '0;

    // Reject illegal framing lengths at elaboration.
    if ((int'(PREAMBLE) < int'(PRE_MIN)) || (PREAMBLE > PRE_MAX) ||
        (int'(POSTAMBLE) < int'(POST_MIN)) || (POSTAMBLE > POST_MAX)) begin : g_bad_param
        $error("ddio_out_burst_ctrl: PREAMBLE must be 1..15 and POSTAMBLE 0..15");
    end

    burst_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_h_q;
    logic [WIDTH-1:0] data_l_q;
    logic             oe_q;
    logic             clkena_q;
    logic             underrun_q;

    // FSM, framing counter and registered DDIO-side outputs.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_h_q   <= '0;
            data_l_q   <= '0;
            oe_q       <= 1'b0;
            clkena_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            // Default for every non-idle cycle: zero data with oe high.
            clkena_q   <= 1'b1;
            underrun_q <= 1'b0;
            data_h_q   <= '0;
            data_l_q   <= '0;
            oe_q       <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    // The idle cycle itself is the mandatory oe-low gap between bursts.
                    oe_q <= 1'b0;
                    if (in_valid) begin
                        state_q <= StPre;
                        cnt_q   <= PreLoad;
                    end
                end
                StPre: begin
                    if (cnt_q == '0) begin
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StData: begin
                    if (in_valid) begin
                        data_h_q <= in_data[2*WIDTH-1:WIDTH];
                        data_l_q <= in_data[WIDTH-1:0];
                        if (in_last) begin
                            if (POSTAMBLE > 0) begin
                                state_q <= StPost;
                                cnt_q   <= PostLoad;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end else begin
                        // Stall: emit a zero cycle but keep the burst open.
                        underrun_q <= 1'b1;
                    end
                end
                StPost: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stream-side status decodes from state only.
    always_comb begin
        in_ready = (state_q == StData);
        busy     = (state_q != StIdle);
    end

    assign datain_h = data_h_q;
    assign datain_l = data_l_q;
    assign oe       = oe_q;
    assign clkena   = clkena_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_ddio_out_burst_ctrl.sv
// Bench for ddio_out_burst_ctrl: a per-cycle vector table on a PREAMBLE=1/POSTAMBLE=1
// instance, plus a hand-driven back-to-back burst sequence on a PREAMBLE=3/POSTAMBLE=0 one.
module tb_ddio_out_burst_ctrl;

    logic clk;
    logic sreset;

    // Instance A: PREAMBLE=1, POSTAMBLE=1.
    logic        a_valid, a_ready, a_last, a_oe, a_clkena, a_busy, a_underrun;
    logic [15:0] a_data;
    logic [7:0]  a_h, a_l;

    // Instance B: PREAMBLE=3, POSTAMBLE=0.
    logic        b_valid, b_ready, b_last, b_oe, b_clkena, b_busy, b_underrun;
    logic [15:0] b_data;
    logic [7:0]  b_h, b_l;

    int passed = 0;
    int total  = 0;

    ddio_out_burst_ctrl #(.WIDTH(8), .PREAMBLE(1), .POSTAMBLE(1)) dut_a (
        .clk      (clk),
        .sreset   (sreset),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_data  (a_data),
        .in_last  (a_last),
        .datain_h (a_h),
        .datain_l (a_l),
        .oe       (a_oe),
        .clkena   (a_clkena),
        .busy     (a_busy),
        .underrun (a_underrun)
    );

    ddio_out_burst_ctrl #(.WIDTH(8), .PREAMBLE(3), .POSTAMBLE(0)) dut_b (
        .clk      (clk),
        .sreset   (sreset),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_data  (b_data),
        .in_last  (b_last),
        .datain_h (b_h),
        .datain_l (b_l),
        .oe       (b_oe),
        .clkena   (b_clkena),
        .busy     (b_busy),
        .underrun (b_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic        ck;
        logic        e_ready;
        logic        e_busy;
        logic        e_oe;
        logic [15:0] e_hl;
        logic        e_und;
        logic        e_ce;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic valid, input logic [15:0] data,
                       input logic last, input logic ck, input logic rdy, input logic bsy,
                       input logic oe_e, input logic [15:0] hl, input logic und,
                       input logic ce);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.ck = ck;
        v.e_ready = rdy; v.e_busy = bsy; v.e_oe = oe_e; v.e_hl = hl; v.e_und = und;
        v.e_ce = ce;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    logic [15:0] b_words [4];
    logic        b_exp_oe [14];
    logic [15:0] b_exp_hl [14];

    initial begin
        sreset  = 1'b1;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;

        // rst, v, data, last, ck | ready, busy, oe, {h,l}, underrun, clkena
        // Power-up reset, then idle.
        add(1, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0000, 0, 1);
        // 4-word burst.
        add(0, 1, 16'hA1B1, 0, 1,  0, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hA1B1, 0, 1,  0, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hA1B1, 0, 1,  1, 1, 1, 16'h0000, 0, 1);
        add(0, 1, 16'hA2B2, 0, 1,  1, 1, 1, 16'hA1B1, 0, 1);
        add(0, 1, 16'hA3B3, 0, 1,  1, 1, 1, 16'hA2B2, 0, 1);
        add(0, 1, 16'hA4B4, 1, 1,  1, 1, 1, 16'hA3B3, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 1, 1, 16'hA4B4, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0, 1);
        // Single word with last.
        add(0, 1, 16'h5AA5, 1, 1,  0, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h5AA5, 1, 1,  0, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h5AA5, 1, 1,  1, 1, 1, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 1, 1, 16'h5AA5, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0, 1);
        // 3-word burst with a one-cycle stall after word 1.
        add(0, 1, 16'hC1D1, 0, 1,  0, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hC1D1, 0, 1,  0, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hC1D1, 0, 1,  1, 1, 1, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  1, 1, 1, 16'hC1D1, 0, 1);
        add(0, 1, 16'hC2D2, 0, 1,  1, 1, 1, 16'h0000, 1, 1);
        add(0, 1, 16'hC3D3, 1, 1,  1, 1, 1, 16'hC2D2, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 1, 1, 16'hC3D3, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0, 1);
        // Reset during word 2 of a 4-word burst, then a fresh single-word burst.
        add(0, 1, 16'hE1F1, 0, 1,  0, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hE1F1, 0, 1,  0, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hE1F1, 0, 1,  1, 1, 1, 16'h0000, 0, 1);
        add(1, 1, 16'hE2F2, 0, 1,  1, 1, 1, 16'hE1F1, 0, 1);
        add(1, 1, 16'hE2F2, 0, 1,  0, 0, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h7788, 1, 1,  0, 0, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h7788, 1, 1,  0, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h7788, 1, 1,  1, 1, 1, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 1, 1, 16'h7788, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0000, 0, 1);

        // Each row: outputs of this cycle are checked, then this cycle's inputs are driven.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].ck) begin
                check("in_ready", i, 32'(a_ready), 32'(vecs[i].e_ready));
                check("busy", i, 32'(a_busy), 32'(vecs[i].e_busy));
                check("oe", i, 32'(a_oe), 32'(vecs[i].e_oe));
                check("datain_h", i, 32'(a_h), 32'(vecs[i].e_hl[15:8]));
                check("datain_l", i, 32'(a_l), 32'(vecs[i].e_hl[7:0]));
                check("underrun", i, 32'(a_underrun), 32'(vecs[i].e_und));
                check("clkena", i, 32'(a_clkena), 32'(vecs[i].e_ce));
            end
            sreset  = vecs[i].rst;
            a_valid = vecs[i].valid;
            a_data  = vecs[i].data;
            a_last  = vecs[i].last;
        end

        // Instance B: two 2-word bursts with valid held high; 3 zero cycles of preamble,
        // no postamble, exactly one oe-low cycle between the bursts.
        b_words[0] = 16'h1122; b_words[1] = 16'h3344;
        b_words[2] = 16'h5566; b_words[3] = 16'h7788;
        b_exp_oe = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        b_exp_hl = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1122, 16'h3344,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5566, 16'h7788, 16'h0000};
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 14; c++) begin
                logic hs;
                @(negedge clk);
                check("b_oe", c, 32'(b_oe), 32'(b_exp_oe[c]));
                check("b_datain", c, {16'h0, b_h, b_l}, {16'h0, b_exp_hl[c]});
                check("b_underrun", c, 32'(b_underrun), 32'(0));
                b_valid = (idx < 4);
                b_data  = (idx < 4) ? b_words[idx] : 16'h0000;
                b_last  = (idx == 1) || (idx == 3);
                hs = b_valid && b_ready;
                @(posedge clk);
                if (hs) idx++;
            end
            check("b_words_consumed", 0, 32'(idx), 32'(4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
